uart_rx_pattern_checker: RTL
============================

Name: uart_rx_pattern_checker

Overview:
- Receive-side counterpart of the UART data top's transmit pattern source; sits after uart_Top's receiver and consumes each received byte on rx_Data/rx_Done.
- Expected stream is the repeating pattern 0x11,0x22,...,0x88, which is the sequence the transmit side writes.
- Synchronises to the pattern, checks every byte against the expected value and keeps byte/error statistics.
- Drives lock and error indications for LEDs and debug.

Parameters:
- PATTERN_LEN, 8, number of bytes in one pattern period; legal range 1..15.
- LOSS_THRESH, 3, consecutive mismatches in LOCKED that force a return to HUNT; legal range 1..15.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-low reset.
- rx_Data  input  8  received byte; valid only in the cycle rx_Done is high.
- rx_Done  input  1  single-cycle strobe from the UART receiver, one per received byte.
- clr_Stat  input  1  synchronous clear of byte_Cnt, err_Cnt and pass_Cnt.
- locked  output  1  high while the FSM is in LOCKED.
- err_Pulse  output  1  one-cycle pulse per mismatched byte while LOCKED.
- pass_Pulse  output  1  one-cycle pulse when a full pattern period completes with zero mismatches.
- exp_Data  output  8  expected value for the next byte; 0x11 while in HUNT.
- byte_Cnt  output  CNT_W  bytes accepted since the last clear, counted in every state.
- err_Cnt  output  CNT_W  mismatches detected in LOCKED.
- pass_Cnt  output  CNT_W  error-free pattern periods completed.

Behaviour:
- Expected value at index i (0..PATTERN_LEN-1) = {i+1 in 4 bits, i+1 in 4 bits}, so i=0 gives 0x11 and i=7 gives 0x88.
- Reset applies when reset is low at a clk edge:
  - state=HUNT, idx=0, miss=0, per-period error flag clear.
  - locked=0, err_Pulse=0, pass_Pulse=0, exp_Data=0x11.
  - All counters=0.
  - Reset asserted mid-byte or mid-period discards all progress.
- All outputs are registered. A byte strobed in cycle N is reflected in all outputs at edge N+1 (latency 1). With no rx_Done, the state does not change and the pulses are 0.
- HUNT, on rx_Done:
  - If rx_Data==0x11: go to LOCKED, idx=1 (wrap to 0 if PATTERN_LEN==1), miss=0, period error flag clear.
  - Otherwise stay in HUNT.
  - Bytes received in HUNT never increment err_Cnt.
- LOCKED, on rx_Done, compare rx_Data with expected[idx]:
  - Match: miss=0.
  - Mismatch: err_Cnt+1, err_Pulse=1 for one cycle, miss+1, set period error flag.
  - idx always advances, wrapping PATTERN_LEN-1 -> 0; the FSM does not resynchronise on the received value.
  - When idx wraps: if the period error flag is clear (including the current byte), pass_Pulse=1 and pass_Cnt+1. The flag clears for the new period.
  - If miss reaches LOSS_THRESH: go to HUNT, idx=0, locked=0 on the same edge. err_Pulse still fires for that byte. A byte equal to 0x11 that causes loss is not re-used for sync.
- exp_Data always shows expected[idx] for the next byte. In HUNT it shows 0x11.
- byte_Cnt increments on every rx_Done in either state.
- All counters saturate at 2^CNT_W-1 and never wrap.
- If clr_Stat and rx_Done occur in the same cycle, clear wins: all three counters become 0 and that byte is not counted. FSM, idx, miss and the pulses still process that byte normally.
- rx_Done is assumed to be a one-cycle strobe. If it is held high for k cycles, it is treated as k bytes.

Test Plan:
- Reset, then stream 0x11..0x88 twice -> locked=1 one cycle after the first 0x11; two pass_Pulse, both on the 0x88 bytes; byte_Cnt=16, err_Cnt=0, pass_Cnt=2.
- Send 0x55, 0xA0, then 0x11..0x88 -> first two bytes ignored in HUNT, then lock; byte_Cnt=10, err_Cnt=0, pass_Cnt=1.
- While locked, corrupt one byte (0x44 sent as 0x45) -> one err_Pulse, err_Cnt=1, locked stays 1, no pass_Pulse for that period, pass_Pulse resumes on the next clean period.
- While locked, send three consecutive wrong bytes (LOSS_THRESH=3) -> err_Cnt=3, locked=0 after the third; a following 0x11 relocks.
- Assert clr_Stat together with rx_Done on a matching byte -> all counters 0 next cycle, idx still advances (exp_Data steps to the next value).
- Drive reset low mid-period while locked -> next edge locked=0, exp_Data=0x11, all counters 0; resume with 0x22 -> stays in HUNT.

Source files
------------

// File: rtl/uart_rx_pattern_checker.sv
// rtl/uart_rx_pattern_checker.sv - UART receive-side pattern lock/check with statistics
module uart_rx_pattern_checker #(
    parameter int PATTERN_LEN = 8,
    parameter int LOSS_THRESH = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_Data,
    input  logic             rx_Done,
    input  logic             clr_Stat,
    output logic             locked,
    output logic             err_Pulse,
    output logic             pass_Pulse,
    output logic [7:0]       exp_Data,
    output logic [CNT_W-1:0] byte_Cnt,
    output logic [CNT_W-1:0] err_Cnt,
    output logic [CNT_W-1:0] pass_Cnt
);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [3:0]       LAST_IDX  = 4'(PATTERN_LEN - 1);
    localparam logic [3:0]       LOSS_LVL  = 4'(LOSS_THRESH);
    localparam logic [3:0]       LOCK_IDX  = (PATTERN_LEN == 1) ? 4'd0 : 4'd1;
    localparam logic [7:0]       SYNC_BYTE = 8'h11;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // Pattern byte for a given index: the index+1 nibble repeated
    function automatic logic [7:0] pat_byte(input logic [3:0] idx);
        logic [3:0] n;
        n = idx + 4'd1;
        return {n, n};
    endfunction

    // Counters stick at all-ones rather than wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic [0:0]       state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       miss_q, miss_d;
    logic             perr_q, perr_d;
    logic             err_pulse_q, err_pulse_d;
    logic             pass_pulse_q, pass_pulse_d;
    logic [7:0]       exp_q, exp_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;

    logic             mismatch;
    logic [3:0]       miss_inc;
    logic             perr_now;
    logic             wrap;

    // Per-byte next-state: sync in HUNT, compare/advance/loss detection in LOCKED
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        miss_d       = miss_q;
        perr_d       = perr_q;
        err_pulse_d  = 1'b0;
        pass_pulse_d = 1'b0;
        byte_cnt_d   = byte_cnt_q;
        err_cnt_d    = err_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        mismatch     = (rx_Data != pat_byte(idx_q));
        miss_inc     = miss_q + 4'd1;
        perr_now     = perr_q | mismatch;
        wrap         = (idx_q == LAST_IDX);

        if (rx_Done) begin
            byte_cnt_d = sat_inc(byte_cnt_q);
            if (state_q == ST_HUNT) begin
                if (rx_Data == SYNC_BYTE) begin
                    state_d = ST_LOCKED;
                    idx_d   = LOCK_IDX;
                    miss_d  = 4'd0;
                    perr_d  = 1'b0;
                end
            end else begin
                if (mismatch) begin
                    err_pulse_d = 1'b1;
                    err_cnt_d   = sat_inc(err_cnt_q);
                    miss_d      = miss_inc;
                end else begin
                    miss_d      = 4'd0;
                end
                // The index always advances; the received value never resynchronises it
                if (wrap) begin
                    idx_d  = 4'd0;
                    perr_d = 1'b0;
                    if (!perr_now) begin
                        pass_pulse_d = 1'b1;
                        pass_cnt_d   = sat_inc(pass_cnt_q);
                    end
                end else begin
                    idx_d  = idx_q + 4'd1;
                    perr_d = perr_now;
                end
                // Too many misses in a row: drop lock, this byte is not reused for sync
                if (mismatch && (miss_inc >= LOSS_LVL)) begin
                    state_d = ST_HUNT;
                    idx_d   = 4'd0;
                    miss_d  = 4'd0;
                    perr_d  = 1'b0;
                end
            end
        end

        if (clr_Stat) begin
            byte_cnt_d = '0;
            err_cnt_d  = '0;
            pass_cnt_d = '0;
        end

        exp_d = (state_d == ST_LOCKED) ? pat_byte(idx_d) : SYNC_BYTE;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_HUNT;
            idx_q        <= 4'd0;
            miss_q       <= 4'd0;
            perr_q       <= 1'b0;
            err_pulse_q  <= 1'b0;
            pass_pulse_q <= 1'b0;
            exp_q        <= SYNC_BYTE;
            byte_cnt_q   <= '0;
            err_cnt_q    <= '0;
            pass_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            miss_q       <= miss_d;
            perr_q       <= perr_d;
            err_pulse_q  <= err_pulse_d;
            pass_pulse_q <= pass_pulse_d;
            exp_q        <= exp_d;
            byte_cnt_q   <= byte_cnt_d;
            err_cnt_q    <= err_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
        end
    end

    assign locked     = (state_q == ST_LOCKED);
    assign err_Pulse  = err_pulse_q;
    assign pass_Pulse = pass_pulse_q;
    assign exp_Data   = exp_q;
    assign byte_Cnt   = byte_cnt_q;
    assign err_Cnt    = err_cnt_q;
    assign pass_Cnt   = pass_cnt_q;

endmodule
